apb_master_bridge: RTL and testbench

//   APB3 requester stage feeding the memory-backed APB slave. Converts a simple

---
 rtl/apb_master_bridge.sv | 164 ++++++++++++++++
 tb/tb_apb_master_bridge.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// -----------------------------------------------------------------------------
// apb_master_bridge
//   APB3 requester. Accepts one command at a time from a valid/ready stream,
//   runs it as an IDLE -> SETUP -> ACCESS transfer and returns the result on a
//   valid/ready response channel. A transfer is abandoned after TIMEOUT ACCESS
//   cycles without PREADY.
//
// Ports
//   PCLK, PRESET                  clock, asynchronous active-low reset
//   cmd_valid/cmd_ready           command handshake
//   cmd_write/cmd_addr/cmd_wdata  command payload
//   rsp_valid/rsp_ready           response handshake
//   rsp_rdata/rsp_err/rsp_timeout response payload
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA   APB request signals (registered)
//   PRDATA/PREADY/PSLVERR              APB completion signals
// -----------------------------------------------------------------------------
module apb_master_bridge #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_alive;
    logic [CNT_W-1:0] r_cnt;
    logic             w_accept;
    logic             w_done_ok;
    logic             w_done_to;

    // r_alive keeps cmd_ready low until the first edge after reset release,
    // so every output reads 0 while PRESET is asserted.
    assign cmd_ready = r_alive && (r_state == ST_IDLE) && (!rsp_valid || rsp_ready);

    // State register
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and transfer completion qualifiers
    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_done_ok = 1'b0;
        w_done_to = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    w_accept = 1'b1;
                    w_next   = ST_SETUP;
                end else begin
                    w_next   = ST_IDLE;
                end
            end
            ST_SETUP: begin
                w_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (PREADY) begin
                    w_done_ok = 1'b1;
                    w_next    = ST_IDLE;
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    // r_cnt holds the number of stalled ACCESS edges already
                    // seen, so this edge ends the TIMEOUT-th ACCESS cycle.
                    w_done_to = 1'b1;
                    w_next    = ST_IDLE;
                end else begin
                    w_next    = ST_ACCESS;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // APB request outputs, wait counter and response registers
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            r_alive     <= 1'b0;
            r_cnt       <= {CNT_W{1'b0}};
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PADDR       <= {ADDR_W{1'b0}};
            PWDATA      <= {DATA_W{1'b0}};
            rsp_valid   <= 1'b0;
            rsp_rdata   <= {DATA_W{1'b0}};
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            r_alive <= 1'b1;
            // Derived from the next state so the APB phase lines are registered.
            PSEL    <= (w_next != ST_IDLE);
            PENABLE <= (w_next == ST_ACCESS);

            if (w_accept) begin
                PWRITE <= cmd_write;
                PADDR  <= cmd_addr;
                PWDATA <= cmd_wdata;
                r_cnt  <= {CNT_W{1'b0}};
            end else if ((r_state == ST_ACCESS) && !PREADY) begin
                r_cnt  <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                r_cnt  <= r_cnt;
            end

            // A transfer only starts once the previous response is gone, so a
            // completion never coincides with a response handshake.
            if (w_done_ok) begin
                rsp_valid   <= 1'b1;
                rsp_rdata   <= (PWRITE || PSLVERR) ? {DATA_W{1'b0}} : PRDATA;
                rsp_err     <= PSLVERR;
                rsp_timeout <= 1'b0;
            end else if (w_done_to) begin
                rsp_valid   <= 1'b1;
                rsp_rdata   <= {DATA_W{1'b0}};
                rsp_err     <= 1'b1;
                rsp_timeout <= 1'b1;
            end else if (rsp_valid && rsp_ready) begin
                rsp_valid   <= 1'b0;
                rsp_rdata   <= {DATA_W{1'b0}};
                rsp_err     <= 1'b0;
                rsp_timeout <= 1'b0;
            end else begin
                rsp_valid   <= rsp_valid;
            end
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// -----------------------------------------------------------------------------
// tb_apb_master_bridge
//   Directed bench for apb_master_bridge with a memory-backed APB slave, a
//   transaction-level reference model checked every cycle, and literal checks
//   on the headline scenarios.
// -----------------------------------------------------------------------------
module tb_apb_master_bridge;

    localparam int TIMEOUT = 16;

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = 32'h0;
    logic [31:0] cmd_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA = 32'h0;
    logic        PREADY = 1'b0;
    logic        PSLVERR = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    apb_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- APB slave: memory, programmable wait, hang, error ------
    int          s_wait = 0;
    bit          s_hang = 1'b0;
    logic [31:0] s_mem [logic [31:0]];

    initial begin
        int          acc_n;
        bit          rdy;
        bit          pend_wr;
        logic [31:0] pend_a, pend_d;
        acc_n = 0; pend_wr = 1'b0; pend_a = 32'h0; pend_d = 32'h0;
        forever begin
            @(posedge PCLK); #1;
            if (pend_wr) s_mem[pend_a] = pend_d;
            pend_wr = 1'b0;
            if (PSEL && PENABLE) begin
                acc_n++;
                rdy = !s_hang && (acc_n > s_wait);
            end else begin
                acc_n = 0;
                rdy = 1'b0;
            end
            PREADY  = rdy;
            PSLVERR = rdy && (PADDR == 32'h40);
            PRDATA  = (rdy && !PWRITE && s_mem.exists(PADDR)) ? s_mem[PADDR] : 32'h0;
            if (rdy && PWRITE) begin
                pend_wr = 1'b1; pend_a = PADDR; pend_d = PWDATA;
            end
        end
    end

    // ---------------- reference model + per-cycle compare --------------------
    // Inputs only change just after a rising edge, so values seen at the
    // falling edge are exactly the ones the DUT samples at the next rising edge.
    initial begin
        bit          m_alive, m_busy, m_rv, m_write, m_err, m_to;
        int          m_age;
        logic [31:0] m_addr, m_wdata, m_rdata;
        logic [31:0] m_mem [logic [31:0]];
        bit          e_rdy, acc, hs;
        m_alive = 0; m_busy = 0; m_rv = 0; m_write = 0; m_err = 0; m_to = 0;
        m_age = 0; m_addr = 0; m_wdata = 0; m_rdata = 0;
        forever begin
            @(negedge PCLK);
            if (!PRESET) begin
                m_alive = 0; m_busy = 0; m_rv = 0; m_write = 0; m_err = 0; m_to = 0;
                m_age = 0; m_addr = 0; m_wdata = 0; m_rdata = 0;
            end
            e_rdy = m_alive && !m_busy && (!m_rv || rsp_ready);
            check("psel",        PSEL,        m_busy);
            check("penable",     PENABLE,     m_busy && (m_age >= 1));
            check("cmd_ready",   cmd_ready,   e_rdy);
            check("rsp_valid",   rsp_valid,   m_rv);
            check("rsp_rdata",   rsp_rdata,   m_rdata);
            check("rsp_err",     rsp_err,     m_err);
            check("rsp_timeout", rsp_timeout, m_to);
            check("paddr",       PADDR,       m_addr);
            check("pwrite",      PWRITE,      m_write);
            check("pwdata",      PWDATA,      m_wdata);
            if (PRESET) begin
                if (!m_alive) begin
                    m_alive = 1;
                end else if (!m_busy) begin
                    acc = cmd_valid && e_rdy;
                    hs  = m_rv && rsp_ready;
                    if (hs) begin
                        m_rv = 0; m_rdata = 0; m_err = 0; m_to = 0;
                    end
                    if (acc) begin
                        m_busy = 1; m_age = 0;
                        m_addr = cmd_addr; m_write = cmd_write; m_wdata = cmd_wdata;
                    end
                end else if (m_age == 0) begin
                    m_age = 1;
                end else if (PREADY) begin
                    m_busy = 0; m_rv = 1; m_to = 0;
                    m_err  = (m_addr == 32'h40);
                    if (m_write) begin
                        m_mem[m_addr] = m_wdata;
                        m_rdata = 0;
                    end else if (m_err || !m_mem.exists(m_addr)) begin
                        m_rdata = 0;
                    end else begin
                        m_rdata = m_mem[m_addr];
                    end
                end else if (m_age == TIMEOUT) begin
                    m_busy = 0; m_rv = 1; m_err = 1; m_to = 1; m_rdata = 0;
                end else begin
                    m_age++;
                end
            end
        end
    end

    // ---------------- stimulus helpers ---------------------------------------
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data);
        int n;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data;
        n = 0;
        do begin
            @(negedge PCLK);
            n++;
        end while (!cmd_ready && n < 50);
        check("issue_accept", cmd_ready, 1'b1);
        @(posedge PCLK); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int psel_n, output int pen_n);
        int n;
        psel_n = 0; pen_n = 0; n = 0;
        do begin
            @(negedge PCLK);
            n++;
            if (PSEL) psel_n++;
            if (PENABLE) pen_n++;
        end while (!rsp_valid && n < 100);
        check("wait_rsp", rsp_valid, 1'b1);
    endtask

    task automatic consume();
        @(posedge PCLK); #1;
        rsp_ready = 1'b1;
        @(posedge PCLK); #1;
        rsp_ready = 1'b0;
    endtask

    // ---------------- directed scenarios -------------------------------------
    initial begin
        int ps, pe;
        repeat (3) @(posedge PCLK);
        #1 PRESET = 1'b1;
        repeat (2) @(posedge PCLK);
        #1;

        // Write 0x04 <- DEADBEEF, no wait states
        s_wait = 0;
        issue(1'b1, 32'h04, 32'hDEADBEEF);
        wait_rsp(ps, pe);
        check("wr_psel_cycles", ps, 2);
        check("wr_penable_cycles", pe, 1);
        check("wr_rsp_err", rsp_err, 1'b0);
        check("wr_rsp_rdata", rsp_rdata, 32'h0);
        consume();

        // Read 0x04 with three stalled ACCESS cycles
        s_wait = 3;
        issue(1'b0, 32'h04, 32'h0);
        wait_rsp(ps, pe);
        check("rd_penable_cycles", pe, 4);
        check("rd_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
        check("rd_rsp_err", rsp_err, 1'b0);
        consume();

        // Read 0x40: slave error
        s_wait = 0;
        issue(1'b0, 32'h40, 32'h0);
        wait_rsp(ps, pe);
        check("err_rsp_err", rsp_err, 1'b1);
        check("err_rsp_timeout", rsp_timeout, 1'b0);
        consume();

        // Slave never ready: timeout after TIMEOUT ACCESS cycles
        s_hang = 1'b1;
        issue(1'b0, 32'h08, 32'h0);
        wait_rsp(ps, pe);
        check("to_penable_cycles", pe, TIMEOUT);
        check("to_rsp_err", rsp_err, 1'b1);
        check("to_rsp_timeout", rsp_timeout, 1'b1);
        check("to_rsp_rdata", rsp_rdata, 32'h0);
        consume();
        s_hang = 1'b0;

        // Normal traffic after a timeout
        issue(1'b1, 32'h08, 32'h12345678);
        wait_rsp(ps, pe);
        check("post_to_err", rsp_err, 1'b0);
        consume();
        issue(1'b0, 32'h08, 32'h0);
        wait_rsp(ps, pe);
        check("post_to_rdata", rsp_rdata, 32'h12345678);

        // Response held while rsp_ready low, next command waiting
        @(posedge PCLK); #1;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h04; cmd_wdata = 32'h0;
        for (int i = 0; i < 5; i++) begin
            @(negedge PCLK);
            check("hold_cmd_ready", cmd_ready, 1'b0);
            check("hold_psel", PSEL, 1'b0);
            check("hold_rsp_valid", rsp_valid, 1'b1);
            check("hold_rsp_rdata", rsp_rdata, 32'h12345678);
            @(posedge PCLK); #1;
        end
        rsp_ready = 1'b1;
        @(negedge PCLK);
        check("hs_cmd_ready", cmd_ready, 1'b1);
        @(posedge PCLK); #1;
        rsp_ready = 1'b0; cmd_valid = 1'b0;
        @(negedge PCLK);
        check("hs_psel", PSEL, 1'b1);
        check("hs_rsp_valid", rsp_valid, 1'b0);
        wait_rsp(ps, pe);
        check("hs_rdata", rsp_rdata, 32'hDEADBEEF);
        consume();

        // Reset during ACCESS
        s_wait = 5;
        issue(1'b0, 32'h04, 32'h0);
        @(negedge PCLK);
        @(negedge PCLK);
        check("rst_in_access", PENABLE, 1'b1);
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        #1;
        check("rst_psel_now", PSEL, 1'b0);
        check("rst_penable_now", PENABLE, 1'b0);
        check("rst_rsp_valid_now", rsp_valid, 1'b0);
        repeat (2) @(posedge PCLK);
        #1 PRESET = 1'b1;
        s_wait = 0;
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        check("rst_cmd_ready", cmd_ready, 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(negedge PCLK);
            check("rst_no_stale_rsp", rsp_valid, 1'b0);
        end
        @(posedge PCLK); #1;
        issue(1'b0, 32'h04, 32'h0);
        wait_rsp(ps, pe);
        check("after_rst_rdata", rsp_rdata, 32'hDEADBEEF);
        consume();

        repeat (3) @(posedge PCLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
